// File: rtl/mips_pkg.sv
// Shared types and helpers for the IF stage: instruction width, NOP encoding, fetch FSM states.
// Pure declarations, so there is no latency or backpressure of its own.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        FETCH,
        HALT,
        FAULT
    } fetch_state_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr & 32'h3) == 32'h0;
    endfunction

    // True when all four bytes of the word at addr lie inside the image; 33 bits so addr+3 cannot wrap
    function automatic logic word_fits(input logic [31:0] addr, input logic [31:0] bytes);
        return ({1'b0, addr} + 33'd3) < {1'b0, bytes};
    endfunction

endpackage

// File: rtl/imem_word_reader.sv
// Assembles a little-endian 32-bit word from the byte image at addr and flags whether it is in range.
// Purely combinational (zero latency); no flow control, out-of-range reads return zero.
module imem_word_reader
    import mips_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic [7:0]         instruction_mem [MEM_BYTES],
    input  logic [31:0]        addr,
    output logic [INSTR_W-1:0] word,
    output logic               in_range
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [AW-1:0] base;

    always_comb begin
        in_range = word_fits(addr, 32'(MEM_BYTES));
        base     = addr[AW-1:0];
        word     = '0;
        if (in_range) begin
            word = {instruction_mem[base + AW'(3)], instruction_mem[base + AW'(2)],
                    instruction_mem[base + AW'(1)], instruction_mem[base]};
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS IF stage: fetches the word at pc into the IF/ID register, halts on a NOP run, faults on bad addresses.
// One edge from pc to if_instr; stall freezes pc and IF/ID, redirect overrides stall and inserts a bubble.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int          MEM_BYTES = 256,
    parameter int          HALT_NOPS = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         instruction_mem [MEM_BYTES],
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc_plus4,
    output logic               if_valid,
    output logic               halted,
    output logic               fault
);

    localparam int CW = $clog2(HALT_NOPS + 1);
    localparam logic [CW-1:0] NOP_LIMIT = CW'(HALT_NOPS);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [31:0]        if_pc_plus4_q, if_pc_plus4_d;
    logic               if_valid_q, if_valid_d;
    logic [CW-1:0]      nop_cnt_q, nop_cnt_d;

    logic [INSTR_W-1:0] word;
    logic               word_in_range;
    logic [CW-1:0]      nop_cnt_inc;

    imem_word_reader #(
        .MEM_BYTES(MEM_BYTES)
    ) u_reader (
        .instruction_mem(instruction_mem),
        .addr           (pc_q),
        .word           (word),
        .in_range       (word_in_range)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_instr_d    = if_instr_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_valid_d    = if_valid_q;
        nop_cnt_d     = nop_cnt_q;
        nop_cnt_inc   = (nop_cnt_q == NOP_LIMIT) ? nop_cnt_q : nop_cnt_q + CW'(1);

        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    // Bad target is still loaded into pc so the faulting address is visible
                    pc_d       = redirect_pc;
                    if_instr_d = '0;
                    if_valid_d = 1'b0;
                    nop_cnt_d  = '0;
                    if (!is_aligned(redirect_pc) || !word_fits(redirect_pc, 32'(MEM_BYTES))) begin
                        state_d = FAULT;
                    end
                end else if (!word_in_range) begin
                    state_d    = FAULT;
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    if_instr_d    = word;
                    if_pc_plus4_d = pc_q + 32'd4;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    nop_cnt_d     = (word == NOP_WORD) ? nop_cnt_inc : '0;
                    if (word == NOP_WORD && nop_cnt_inc == NOP_LIMIT) begin
                        state_d = HALT;
                    end
                end
            end
            default: begin
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            if_instr_q    <= '0;
            if_pc_plus4_q <= '0;
            if_valid_q    <= 1'b0;
            nop_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_instr_q    <= if_instr_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_valid_q    <= if_valid_d;
            nop_cnt_q     <= nop_cnt_d;
        end
    end

    assign pc          = pc_q;
    assign if_instr    = if_instr_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_valid    = if_valid_q;
    assign halted      = (state_q != FETCH);
    assign fault       = (state_q == FAULT);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF stage of the MIPS pipeline.
- Reads the byte-wide instruction memory image (256 x 8, as loaded by the bench) at the current PC.
- Assembles each 32-bit instruction word, advances the PC, and registers the word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, a halt-on-consecutive-NOP condition and a fetch fault.

Parameters:
- MEM_BYTES, 256, size of instruction memory in bytes.
- HALT_NOPS, 4, number of consecutive fetched NOP words that halts fetch.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instruction_mem  in  [MEM_BYTES-1:0][7:0]  unpacked byte array, instruction image.
- stall  in  1  hazard unit hold; freezes PC and IF/ID.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target byte address.
- pc  out  32  current fetch address.
- if_instr  out  32  IF/ID instruction word.
- if_pc_plus4  out  32  IF/ID PC+4 of that instruction.
- if_valid  out  1  IF/ID holds a real fetched instruction.
- halted  out  1  fetch stopped after HALT_NOPS NOPs.
- fault  out  1  misaligned or out-of-range fetch.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: pc=RESET_PC, if_instr=0, if_pc_plus4=0, if_valid=0, halted=0, fault=0, nop_cnt=0, state=FETCH. Reset overrides all other inputs at the edge.
- Word assembly (combinational): word = {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}. The highest index holds the MS byte. Bytes mem[3..0]=20,0a,00,0a yield 0x200a000a.
- States:
  - FETCH: normal operation.
  - HALT: pc and IF/ID frozen, if_valid=0, halted=1.
  - FAULT: as HALT but fault=1 and halted=1.
  - HALT and FAULT are left only by reset.
- Per-edge priority in FETCH is reset > redirect > fault check > stall > advance.
- redirect_valid=1:
  - pc<=redirect_pc; if_instr<=0; if_valid<=0 (bubble); nop_cnt<=0.
  - Applies even when stall=1.
  - If redirect_pc[1:0]!=0 or redirect_pc+3>=MEM_BYTES: go to FAULT, pc<=redirect_pc (for debug).
- stall=1 without redirect: pc, if_instr, if_pc_plus4, if_valid and nop_cnt all hold.
- Advance:
  - if_instr<=word, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4.
  - Latency: the word at pc appears on if_instr one edge later.
  - The first valid instruction appears on the first rising edge with reset=0.
- Range check before advance: if pc+3>=MEM_BYTES, go to FAULT, if_valid<=0, pc holds. No wrap-around.
- NOP counting:
  - On each advance, nop_cnt<=(word==0) ? nop_cnt+1 : 0.
  - Stalls and bubbles do not count.
  - When the advance makes nop_cnt reach HALT_NOPS: the last NOP is still latched (if_valid=1 that cycle), state<=HALT, pc<=pc+4.
  - On the next edge if_valid<=0.
  - nop_cnt saturates at HALT_NOPS.
- Redirect or stall asserted while in HALT/FAULT: ignored.
- Reset mid-stall or mid-redirect: reset wins; all outputs return to reset values at that edge.
- All arithmetic is 32-bit unsigned. The pc+3 range check is computed at 33 bits to avoid wrap.

Decomposition:
- mips_pkg holds:
  - INSTR_W=32, NOP_WORD=32'h0.
  - typedef enum logic[1:0] {FETCH, HALT, FAULT} fetch_state_t.
  - Function is_aligned(addr).
- One sub-module, imem_word_reader: combinational; inputs instruction_mem and addr; outputs word and in_range.
- The FSM, PC and IF/ID registers stay in instr_fetch_unit.

Test Plan:
- Sequential fetch: load addi image (0x200a000a at 0, 0x200c000b at 4), release reset. Required:
  - Edge 1: if_instr=0x200a000a, if_pc_plus4=4.
  - Edge 2: if_instr=0x200c000b, pc=8.
- Stall: assert stall for 2 cycles at pc=8. Required: pc=8 and if_instr held for both cycles, if_valid unchanged. Release: next edge fetches mem[11:8].
- Redirect vs stall: stall=1 and redirect_valid=1 with redirect_pc=0x14 on the same edge. Required:
  - That edge: if_valid=0, pc=0x14.
  - Next edge (stall low): if_instr=0x018a5820.
- Halt: 3 NOPs then non-NOP then 4 NOPs. Required:
  - No halt after the first 3 NOPs (count cleared by the non-NOP).
  - halted=1 on the edge latching the 4th consecutive NOP.
  - pc then frozen; if_valid=0 from the next edge.
- Faults:
  - redirect_pc=0x06: fault=1, halted=1 next edge.
  - Run to pc=0xFC with no NOP halt: word at 0xFC fetched, then fault at pc=0x100, pc holds.
- Reset mid-operation: assert reset during FAULT. Required: all outputs return to reset values at that edge, and fetch resumes at RESET_PC after release.
